// File: rtl/sseg_scan_controller_pkg.sv
// Shared definitions for the seven-segment display blocks.
// Contents: blank code, scan FSM state encoding, default digit count
// (shared with the segment driver).
package sseg_scan_controller_pkg;

    localparam int unsigned DEFAULT_DIGIT_COUNT = 8;

    // BCD code the driver renders as an unlit digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scanState_t;

endpackage

// File: rtl/sseg_refresh_timer.sv
// Refresh slot timer: prescaler plus round-robin digit index.
// Ports:
//   clkIn, rstIn  clock, asynchronous active-high reset
//   enIn          advance the prescaler this cycle
//   clrIn         synchronously return prescaler and index to zero
//   idxOut        current digit index (registered)
//   slotEnd_c     last cycle of the current digit slot (combinational)
//   frameEnd_c    last cycle of the last digit's slot (combinational)
module sseg_refresh_timer #(
    parameter int unsigned DIGIT_COUNT = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                           clkIn,
    input  logic                           rstIn,
    input  logic                           enIn,
    input  logic                           clrIn,
    output logic [$clog2(DIGIT_COUNT)-1:0] idxOut,
    output logic                           slotEnd_c,
    output logic                           frameEnd_c
);

    localparam int unsigned IW = $clog2(DIGIT_COUNT);
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_COUNT - 1);

    logic [PW-1:0] presc;

    assign slotEnd_c  = enIn && !clrIn && (presc == PRESC_LAST);
    assign frameEnd_c = slotEnd_c && (idxOut == IDX_LAST);

    // Prescaler wraps at terminal count and steps the digit index
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            presc  <= '0;
            idxOut <= '0;
        end else if (clrIn) begin
            presc  <= '0;
            idxOut <= '0;
        end else if (enIn) begin
            if (presc == PRESC_LAST) begin
                presc  <= '0;
                idxOut <= (idxOut == IDX_LAST) ? '0 : idxOut + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_controller.sv
// Seven-segment scan scheduler: round-robins one BCD digit per refresh slot
// onto the driver, with shadow-register updates committed only between
// frames and optional leading-zero blanking.
// Ports:
//   clkIn, rstIn   clock, asynchronous active-high reset
//   enIn           1 = scan, 0 = idle with display blanked
//   loadIn         strobe capturing valueIn into the shadow register
//   valueIn        packed BCD, nibble k = digit k (digit 0 least significant)
//   selOut         digit select to the driver
//   bcdOut         BCD code to the driver, 4'hF = blank
//   frameDoneOut   pulse when the last digit's slot ends
//   pendingOut     shadow holds a value not yet committed
module sseg_scan_controller
    import sseg_scan_controller_pkg::*;
#(
    parameter int unsigned DIGIT_COUNT      = DEFAULT_DIGIT_COUNT,
    parameter int unsigned REFRESH_DIV      = 100000,
    parameter bit          BLANK_LEAD_ZEROS = 1'b1
) (
    input  logic                           clkIn,
    input  logic                           rstIn,
    input  logic                           enIn,
    input  logic                           loadIn,
    input  logic [4*DIGIT_COUNT-1:0]       valueIn,
    output logic [$clog2(DIGIT_COUNT)-1:0] selOut,
    output logic [3:0]                     bcdOut,
    output logic                           frameDoneOut,
    output logic                           pendingOut
);

    localparam int unsigned IW = $clog2(DIGIT_COUNT);
    localparam int unsigned VW = 4 * DIGIT_COUNT;

    scanState_t             state, stateNext;
    logic [VW-1:0]          shadow, shadowNext;
    logic [VW-1:0]          active, activeNext;
    logic [IW-1:0]          selNext;
    logic [IW-1:0]          idx;
    logic [3:0]             bcdNext;
    logic [3:0]             digitVal;
    logic                   digitBlank;
    logic                   frameDoneNext;
    logic                   pendingNext;
    logic                   slotStartQ, slotStartNext;
    logic                   scanning;
    logic                   commitWin;
    logic                   zeroAbove;
    logic                   slotEnd_c;
    logic                   frameEnd_c;
    logic [DIGIT_COUNT-1:0] blankMask;

    // Timer only runs while scanning is sustained; dropping enIn clears it at once
    assign scanning = (state == SCAN) && enIn;

    sseg_refresh_timer #(
        .DIGIT_COUNT (DIGIT_COUNT),
        .REFRESH_DIV (REFRESH_DIV)
    ) uTimer (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .enIn       (scanning),
        .clrIn      (!scanning),
        .idxOut     (idx),
        .slotEnd_c  (slotEnd_c),
        .frameEnd_c (frameEnd_c)
    );

    // Next-state, commit, blanking and output selection
    always_comb begin
        stateNext     = state;
        selNext       = selOut;
        bcdNext       = bcdOut;
        frameDoneNext = 1'b0;
        slotStartNext = slotStartQ;
        shadowNext    = shadow;
        activeNext    = active;
        pendingNext   = pendingOut;
        zeroAbove     = 1'b1;
        blankMask     = '0;
        digitVal      = '0;
        digitBlank    = 1'b0;

        case (state)
            IDLE:    if (enIn)  stateNext = SCAN;
            SCAN:    if (!enIn) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Nothing is on display in IDLE, so committing there cannot tear
        commitWin = (state == IDLE) || frameEnd_c;

        if (loadIn) begin
            shadowNext = valueIn;
            if (commitWin) begin
                activeNext  = valueIn;
                pendingNext = 1'b0;
            end else begin
                pendingNext = 1'b1;
            end
        end else if (commitWin && pendingOut) begin
            activeNext  = shadow;
            pendingNext = 1'b0;
        end

        // Walk down from the top nibble; digit 0 always shows
        for (int k = int'(DIGIT_COUNT) - 1; k >= 0; k--) begin
            zeroAbove    = zeroAbove && (active[4*k +: 4] == 4'h0);
            blankMask[k] = BLANK_LEAD_ZEROS && (k != 0) && zeroAbove;
        end

        for (int k = 0; k < int'(DIGIT_COUNT); k++) begin
            if (idx == IW'(k)) begin
                digitVal   = active[4*k +: 4];
                digitBlank = blankMask[k];
            end
        end

        // Outputs load at the first cycle of each slot, one cycle behind the timer
        if (!scanning) begin
            selNext       = '0;
            bcdNext       = BCD_BLANK;
            slotStartNext = 1'b1;
        end else begin
            slotStartNext = slotEnd_c;
            frameDoneNext = frameEnd_c;
            if (slotStartQ) begin
                selNext = idx;
                bcdNext = digitBlank ? BCD_BLANK : digitVal;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state        <= IDLE;
            selOut       <= '0;
            bcdOut       <= BCD_BLANK;
            frameDoneOut <= 1'b0;
            pendingOut   <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            slotStartQ   <= 1'b0;
        end else begin
            state        <= stateNext;
            selOut       <= selNext;
            bcdOut       <= bcdNext;
            frameDoneOut <= frameDoneNext;
            pendingOut   <= pendingNext;
            shadow       <= shadowNext;
            active       <= activeNext;
            slotStartQ   <= slotStartNext;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with 4 digits, 4 clocks per slot.
module tb_sseg_scan_controller;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic        enIn;
    logic        loadIn;
    logic [15:0] valueIn;
    logic [1:0]  selOut;
    logic [3:0]  bcdOut;
    logic        frameDoneOut;
    logic        pendingOut;

    int testCnt = 0;
    int failCnt = 0;

    always #5 clkIn = ~clkIn;

    sseg_scan_controller #(
        .DIGIT_COUNT      (4),
        .REFRESH_DIV      (4),
        .BLANK_LEAD_ZEROS (1'b1)
    ) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .enIn         (enIn),
        .loadIn       (loadIn),
        .valueIn      (valueIn),
        .selOut       (selOut),
        .bcdOut       (bcdOut),
        .frameDoneOut (frameDoneOut),
        .pendingOut   (pendingOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic [1:0] s, input logic [3:0] b,
                          input logic fd, input logic pd);
        chk({tag, ".sel"},  32'(selOut),       32'(s));
        chk({tag, ".bcd"},  32'(bcdOut),       32'(b));
        chk({tag, ".fd"},   32'(frameDoneOut), 32'(fd));
        chk({tag, ".pend"}, 32'(pendingOut),   32'(pd));
    endtask

    // Checks len cycles of a frame starting at its first slot; expDig holds the
    // expected driver code per digit. Optionally strobes loadIn at cycle loadAt.
    task automatic checkFrame(input string tag, input logic [15:0] expDig, input int len,
                              input bit doLoad, input int loadAt, input logic [15:0] loadVal);
        logic [1:0] s;
        logic [3:0] b;
        logic       pd;
        for (int i = 0; i < len; i++) begin
            s  = 2'(i / 4);
            b  = expDig[4*s +: 4];
            pd = doLoad && (i > loadAt) && (i <= 14);
            chkOut($sformatf("%s.c%0d", tag, i), s, b, 1'(i == 15), pd);
            if (doLoad && i == loadAt) begin
                loadIn  = 1'b1;
                valueIn = loadVal;
            end else begin
                loadIn = 1'b0;
            end
            @(negedge clkIn);
        end
        loadIn = 1'b0;
    endtask

    initial begin
        rstIn   = 1'b1;
        enIn    = 1'b0;
        loadIn  = 1'b0;
        valueIn = '0;

        // Reset and idle
        repeat (2) @(negedge clkIn);
        chkOut("rst", 2'd0, 4'hF, 1'b0, 1'b0);
        rstIn = 1'b0;
        repeat (3) begin
            @(negedge clkIn);
            chkOut("idle", 2'd0, 4'hF, 1'b0, 1'b0);
        end

        // Load in IDLE commits directly
        loadIn  = 1'b1;
        valueIn = 16'h1234;
        @(negedge clkIn);
        loadIn = 1'b0;
        chk("idleLoad.pend", 32'(pendingOut), 32'd0);
        enIn = 1'b1;
        @(negedge clkIn);
        chkOut("start", 2'd0, 4'hF, 1'b0, 1'b0);
        @(negedge clkIn);

        // Basic scan, then blanking patterns
        checkFrame("f1234", 16'h1234, 16, 1'b1, 0, 16'h0050);
        checkFrame("f0050", 16'hFF50, 16, 1'b1, 0, 16'h0000);
        checkFrame("f0000", 16'hFFF0, 16, 1'b1, 0, 16'h1111);
        // Tear-free: load during digit 1, current frame keeps 1s
        checkFrame("f1111", 16'h1111, 16, 1'b1, 5, 16'h2222);
        // Collision: load lands on the boundary cycle
        checkFrame("f2222", 16'h2222, 16, 1'b1, 14, 16'h9999);
        checkFrame("f9999", 16'h9999, 16, 1'b1, 0, 16'h0A00);

        // Non-decimal nibble counts as nonzero; disable during digit 2
        checkFrame("f0A00", 16'hFA00, 9, 1'b0, 0, 16'h0000);
        chkOut("preDis", 2'd2, 4'hA, 1'b0, 1'b0);
        enIn = 1'b0;
        @(negedge clkIn);
        chkOut("dis", 2'd0, 4'hF, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clkIn);
            chkOut("idle2", 2'd0, 4'hF, 1'b0, 1'b0);
        end

        // Re-enable restarts at digit 0 with full slot lengths
        enIn = 1'b1;
        @(negedge clkIn);
        chkOut("reen", 2'd0, 4'hF, 1'b0, 1'b0);
        @(negedge clkIn);
        checkFrame("fRe", 16'hFA00, 6, 1'b1, 3, 16'h5555);

        // Asynchronous reset mid-frame, between clock edges
        chk("preRst.pend", 32'(pendingOut), 32'd1);
        rstIn = 1'b1;
        #1;
        chkOut("asyncRst", 2'd0, 4'hF, 1'b0, 1'b0);
        @(negedge clkIn);
        rstIn = 1'b0;
        @(negedge clkIn);
        chkOut("postRst", 2'd0, 4'hF, 1'b0, 1'b0);
        @(negedge clkIn);
        checkFrame("fPost", 16'hFFF0, 16, 1'b0, 0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
